// File: rtl/mulv_seq_ctrl.sv
// mulv_seq_ctrl: multi-cycle sequencer for strided vector-multiply (MULV).
// Walks operand A/B memory through a req/gnt handshake, pulses the MAC once
// per element pair and finishes with a single register writeback.
// Optional feature: define MULV_SEQ_ABORT_EN to add the abort/abort_ack ports.
module mulv_seq_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned ELEM_STRIDE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        strd_cyc,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [4:0]        rd_addr,
`ifdef MULV_SEQ_ABORT_EN
    input  logic              abort,
    output logic              abort_ack,
`endif
    output logic              busy,
    output logic              stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_sel,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              acc_last,
    output logic              wb_en,
    output logic [4:0]        wb_addr,
    output logic              done
);

    typedef enum logic [2:0] {
        StIdle, StReqA, StWaitA, StReqB, StWaitB, StMac, StWb
    } state_e;

    localparam logic [ADDR_W-1:0] Stride = ADDR_W'(ELEM_STRIDE);

    state_e            state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic [2:0]        last_q, last_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic [4:0]        rd_q, rd_d;
    logic              acc_clr_q, acc_clr_d;
    logic              abort_req;
    logic              is_last;

`ifdef MULV_SEQ_ABORT_EN
    logic abort_ack_q;

    assign abort_req = abort & (state_q != StIdle);
    assign abort_ack = abort_ack_q;

    // One-cycle acknowledge following an accepted abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_ack_q <= 1'b0;
        end else begin
            abort_ack_q <= abort_req;
        end
    end
`else
    assign abort_req = 1'b0;
`endif

    assign is_last = (k_q == last_q);

    // State and latched-operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            k_q       <= 3'd0;
            last_q    <= 3'd0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            rd_q      <= 5'd0;
            acc_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            last_q    <= last_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            rd_q      <= rd_d;
            acc_clr_q <= acc_clr_d;
        end
    end

    // Next-state logic; running A/B pointers equal base + k*stride (mod 2^ADDR_W)
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        last_d    = last_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        rd_d      = rd_q;
        acc_clr_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StReqA;
                    k_d       = 3'd0;
                    last_d    = strd_cyc;
                    addr_a_d  = base_a;
                    addr_b_d  = base_b;
                    rd_d      = rd_addr;
                    acc_clr_d = 1'b1;
                end
            end
            StReqA:  if (mem_gnt)    state_d = StWaitA;
            StWaitA: if (mem_rvalid) state_d = StReqB;
            StReqB:  if (mem_gnt)    state_d = StWaitB;
            StWaitB: if (mem_rvalid) state_d = StMac;
            StMac: begin
                if (is_last) begin
                    state_d = StWb;
                end else begin
                    state_d  = StReqA;
                    k_d      = k_q + 3'd1;
                    addr_a_d = addr_a_q + Stride;
                    addr_b_d = addr_b_q + Stride;
                end
            end
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Abort overrides every transition
        if (abort_req) begin
            state_d = StIdle;
        end
    end

    // State-decoded outputs; stall is combinational so decode holds on the start cycle
    always_comb begin
        busy     = (state_q != StIdle);
        stall    = busy | (start & ~busy);
        mem_req  = (state_q == StReqA) | (state_q == StReqB);
        mem_sel  = (state_q == StReqB);
        mem_addr = '0;
        if (state_q == StReqA) begin
            mem_addr = addr_a_q;
        end else if (state_q == StReqB) begin
            mem_addr = addr_b_q;
        end
        acc_clr  = acc_clr_q;
        acc_en   = (state_q == StMac) & ~abort_req;
        acc_last = acc_en & is_last;
        wb_en    = (state_q == StWb) & ~abort_req;
        done     = wb_en;
        wb_addr  = rd_q;
    end

endmodule

// File: doc/mulv_seq_ctrl.md
# mulv_seq_ctrl

Multi-cycle sequencer for strided vector-multiply (MULV) instructions. When decode flags a MULV with `conv_en`, this block takes the decoded stride-cycle count, base addresses and destination register. It stalls the pipeline, then walks the operand memory through a request/grant handshake and pulses the MAC accumulator once per element pair. When the walk completes it issues a single register writeback. It sits between the instruction decoder, the data-memory port and the vector MAC/accumulator.

## Interface
- `ADDR_W`, 32, width of memory addresses and base operands
- `ELEM_STRIDE`, 1, address increment per step (in address units)
- `clk`  in  1  system clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  decoder's `conv_en` for the current instruction; sampled only in IDLE
- `strd_cyc`  in  3  step count code; steps N = `strd_cyc` + 1 (1..8)
- `base_a`  in  ADDR_W  operand A start address
- `base_b`  in  ADDR_W  operand B start address
- `rd_addr`  in  5  destination register for result
- `busy`  out  1  high whenever state ≠ IDLE
- `stall`  out  1  combinational `busy | (start & idle)`; freezes fetch/decode
- `mem_req`  out  1  memory read request
- `mem_addr`  out  ADDR_W  request address, stable while `mem_req` high
- `mem_sel`  out  1  0 = operand A fetch, 1 = operand B fetch
- `mem_gnt`  in  1  request accepted this cycle
- `mem_rvalid`  in  1  read data returned (data path not routed here)
- `acc_clr`  out  1  one-cycle accumulator clear at sequence start
- `acc_en`  out  1  one-cycle MAC enable per step
- `acc_last`  out  1  qualifies `acc_en` on final step
- `wb_en`  out  1  one-cycle register-file write strobe
- `wb_addr`  out  5  latched `rd_addr`, valid with `wb_en`
- `done`  out  1  one-cycle completion pulse, coincident with `wb_en`

## Operation
- States: IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B, MAC, WB.
- IDLE: `start`=1 latches `strd_cyc`, `base_a`, `base_b`, `rd_addr` and clears step counter `k`. Asserts `acc_clr` next cycle and enters REQ_A.
- REQ_A: `mem_req`=1, `mem_sel`=0, `mem_addr`=`base_a + k*ELEM_STRIDE` (mod 2^ADDR_W, wrap silently). Stays in REQ_A until `mem_gnt`, then enters WAIT_A.
- WAIT_A: leaves for REQ_B on `mem_rvalid`.
- REQ_B/WAIT_B: same as REQ_A/WAIT_A with `base_b`, `mem_sel`=1. Exit goes to MAC.
- MAC: `acc_en`=1 for one cycle; `acc_last`=1 when `k`==N-1. If last, go to WB; else `k`++ and go to REQ_A.
- WB: `wb_en`=1, `done`=1, `wb_addr`=latched `rd_addr`; next state IDLE.
- `mem_rvalid` outside WAIT_A/WAIT_B is ignored; zero-latency memory (rvalid in grant cycle) is not supported.
- `start` while busy is ignored. Inputs other than `mem_gnt`/`mem_rvalid` are don't-care after latching.
- Reset (any state, mid-sequence included): immediate return to IDLE, `k`=0, no writeback, no `done`.

## Timing
- Reset values: all outputs 0; `mem_addr`=0; `wb_addr`=0; state IDLE.
- All outputs except `stall` are registered/state-decoded; `stall` is combinational so the issuing instruction holds the same cycle `start` rises.
- With `mem_gnt` tied 1 and `mem_rvalid` one cycle after grant: 5 cycles per step. `done` is high in cycle 5N+1 after the `start` edge (N=1 → cycle 6; N=8 → cycle 41).
- Each cycle `mem_gnt` is low adds one cycle to the current REQ state. Each cycle `mem_rvalid` is late adds one cycle to the current WAIT state.
- Back-to-back: `start` high in the cycle after `done` is accepted (IDLE reached).

## Configuration
- `MULV_SEQ_ABORT_EN`: adds input `abort` (1) and output `abort_ack` (1).
- When defined: `abort`=1 in any non-IDLE state forces IDLE next cycle and pulses `abort_ack` one cycle. No `acc_en`, `wb_en` or `done` is issued. An outstanding granted read is dropped and its late `mem_rvalid` is ignored. `abort` in IDLE is ignored. Takes priority over all transitions.
- Undefined: ports absent; sequence always runs to WB.

## Test plan
- Reset mid-sequence: assert `rst_n`=0 in WAIT_B of step 2 → all outputs 0 immediately; no `wb_en`; next `start` runs normally.
- Single step: `strd_cyc`=0, `base_a`=0x100, `base_b`=0x200, `rd_addr`=7, gnt=1, rvalid +1 → addrs 0x100 then 0x200; `acc_en`+`acc_last` at cycle 5; `wb_en`/`done` with `wb_addr`=7 at cycle 6.
- Full length: `strd_cyc`=7, `ELEM_STRIDE`=4 → eight A addrs `base_a`+0..28 step 4; eight `acc_en`, `acc_last` only on the 8th; `done` at cycle 41.
- Backpressure: hold `mem_gnt`=0 for 3 cycles on first REQ_B, delay rvalid by 2 → `mem_addr`/`mem_sel` stable throughout; `done` shifts by exactly 5 cycles.
- Wrap/ignore: `base_a`=0xFFFFFFFF, `strd_cyc`=1 → second A addr 0x00000000. `start` pulsed while busy and a stray `mem_rvalid` in REQ_A → no effect.
- Abort (`MULV_SEQ_ABORT_EN`): `abort` in MAC of step 3 of 8 → `abort_ack` next cycle; IDLE; no `wb_en`/`done`; `busy`=0.
